// File: rtl/mstage_bus_if.sv
// Native valid/ready bus plus run/done handshake between the batch driver and the
// SHA-256 message-schedule test stage.
interface mstage_bus_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  ready;
    logic [DATA_W-1:0]     rdata;
    logic                  run;
    logic                  done;

    modport master (
        output valid, addr, wstrb, wdata, run,
        input  ready, rdata, done
    );

    modport slave (
        input  valid, addr, wstrb, wdata, run,
        output ready, rdata, done
    );
endinterface

// File: rtl/mstage_bus_driver.sv
// Bus initiator: writes four latched words to the stage, pulses run, waits for done,
// reads the result word back and strobes it out.
module mstage_bus_driver #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RES_ADDR = 4,
    parameter int TO_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DATA_W-1:0] w_in,
    input  logic [TO_W-1:0]     timeout_lim,
    output logic                busy,
    output logic                res_valid,
    output logic [DATA_W-1:0]   res_data,
    output logic                err_timeout,
    output logic [2:0]          dbg_state,
    mstage_bus_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_READ  = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [4*DATA_W-1:0] words_q, words_d;
    logic [TO_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic                guard_q, guard_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   res_q, res_d;

    logic                valid_c;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W/8-1:0] wstrb_c;
    logic [DATA_W-1:0]   wdata_c;
    logic                run_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            words_q <= '0;
            cnt_q   <= '0;
            guard_q <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            guard_q <= guard_d;
            err_q   <= err_d;
            res_q   <= res_d;
        end
    end

    assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    // A transfer completes on the rising edge where valid and ready are both high;
    // the request fields hold from the cycle valid rises until that edge and are
    // all zero whenever valid is low.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        guard_d = guard_q;
        err_d   = err_q;
        res_d   = res_q;
        valid_c = 1'b0;
        addr_c  = '0;
        wstrb_c = '0;
        wdata_c = '0;
        run_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    words_d = w_in;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                valid_c = 1'b1;
                addr_c  = ADDR_W'(idx_q);
                wstrb_c = '1;
                wdata_c = words_q[idx_q*DATA_W +: DATA_W];
                if (bus.ready) begin
                    if (idx_q == 2'd3) begin
                        idx_d   = '0;
                        state_d = S_RUN;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_RUN: begin
                run_c   = 1'b1;
                cnt_d   = '0;
                guard_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done may still be high from the previous batch in the guard cycle
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (bus.done) begin
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_inc;
                    if ((timeout_lim != '0) && (cnt_inc == timeout_lim)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_READ: begin
                valid_c = 1'b1;
                addr_c  = ADDR_W'(RES_ADDR);
                if (bus.ready) begin
                    res_d   = bus.rdata;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.valid   = valid_c;
    assign bus.addr    = addr_c;
    assign bus.wstrb   = wstrb_c;
    assign bus.wdata   = wdata_c;
    assign bus.run     = run_c;

    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_RESP);
    assign res_data    = res_q;
    assign err_timeout = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mstage_bus_driver.sv
// Directed bench for mstage_bus_driver: bus/stage model, scoreboard queues checked by
// a negedge monitor, and a final report.
module tb_mstage_bus_driver;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int RES_ADDR = 4;
    localparam int TO_W     = 16;
    localparam int STRB_W   = DATA_W / 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic                start = 1'b0;
    logic [4*DATA_W-1:0] w_in = '0;
    logic [TO_W-1:0]     timeout_lim = '0;
    logic                busy, res_valid, err_timeout;
    logic [DATA_W-1:0]   res_data;
    logic [2:0]          dbg_state;

    mstage_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mstage_bus_driver #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_ADDR(RES_ADDR), .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .w_in(w_in), .timeout_lim(timeout_lim),
        .busy(busy), .res_valid(res_valid), .res_data(res_data),
        .err_timeout(err_timeout), .dbg_state(dbg_state), .bus(bus)
    );

    int cyc = 0;
    int start_c = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    logic [ADDR_W-1:0]        exp_rd_q[$];
    logic [DATA_W-1:0]        exp_res_q[$];
    int                       exp_lat_q[$];
    int                       exp_run_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - start_c);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: event not expected by scoreboard (cycle %0d)", name, cyc - start_c);
    endtask

    // ---------------- bus / stage model ----------------
    int          wr_stall[4] = '{0, 0, 0, 0};
    int          rd_stall = 0;
    int          done_mode = 0;
    logic [DATA_W-1:0] rd_word = '0;

    initial begin
        int wait_cnt;
        int need;
        logic last_xfer;
        bus.ready = 1'b0;
        bus.rdata = '0;
        wait_cnt  = 0;
        last_xfer = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.rdata = rd_word;
            if (last_xfer || !bus.valid) wait_cnt = 0;
            if (!bus.valid) begin
                bus.ready = 1'b0;
            end else begin
                need = (bus.wstrb == '0) ? rd_stall : wr_stall[bus.addr[1:0]];
                if (wait_cnt < need) begin
                    bus.ready = 1'b0;
                    wait_cnt++;
                end else begin
                    bus.ready = 1'b1;
                end
            end
            @(negedge clk);
            last_xfer = bus.valid && bus.ready;
        end
    end

    // done behaviour relative to the run pulse: 0 = rises two cycles after run,
    // 1 = stale high through run/guard then low 5 cycles, 2 = stuck low
    initial begin
        int since;
        since = 1000;
        bus.done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.run) since = 0;
            else if (since < 100000) since++;
            case (done_mode)
                0:       bus.done = (since >= 2);
                1:       bus.done = (since <= 1) || (since >= 7);
                default: bus.done = 1'b0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic prev_stall;
        logic [ADDR_W+STRB_W+DATA_W-1:0] prev_req;
        logic [ADDR_W+DATA_W-1:0] e;
        int spec_c;
        prev_stall = 1'b0;
        prev_req   = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_stall = 1'b0;
                continue;
            end
            spec_c = cyc - start_c;
            if (!bus.valid)
                chk("idle_bus_zero", {bus.addr, bus.wstrb, bus.wdata}, '0);
            else if (prev_stall)
                chk("stall_hold", {bus.addr, bus.wstrb, bus.wdata}, prev_req);
            if (bus.valid && bus.ready) begin
                if (bus.wstrb != '0) begin
                    if (exp_wr_q.size() == 0) fail("unexpected_write");
                    else begin
                        e = exp_wr_q.pop_front();
                        chk("write_addr_data", {bus.addr, bus.wdata}, e);
                        chk("write_strb", bus.wstrb, {STRB_W{1'b1}});
                    end
                end else begin
                    if (exp_rd_q.size() == 0) fail("unexpected_read");
                    else begin
                        chk("read_addr", bus.addr, exp_rd_q.pop_front());
                        chk("read_wdata", bus.wdata, '0);
                    end
                end
            end
            prev_stall = bus.valid && !bus.ready;
            prev_req   = {bus.addr, bus.wstrb, bus.wdata};
            if (bus.run) begin
                if (exp_run_q.size() == 0) fail("unexpected_run");
                else chk("run_cycle", spec_c, exp_run_q.pop_front());
            end
            if (res_valid) begin
                if (exp_res_q.size() == 0) fail("unexpected_res_valid");
                else begin
                    chk("res_data", res_data, exp_res_q.pop_front());
                    if (exp_lat_q[0] >= 0) chk("res_cycle", spec_c, exp_lat_q[0]);
                    void'(exp_lat_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_batch(input logic [DATA_W-1:0] w0, w1, w2, w3);
        @(posedge clk);
        #1;
        w_in    = {w3, w2, w1, w0};
        start   = 1'b1;
        start_c = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic expect_batch(input logic [DATA_W-1:0] w0, w1, w2, w3, input int run_c,
                                input logic has_read, input logic [DATA_W-1:0] res,
                                input int lat);
        exp_wr_q.push_back({ADDR_W'(0), w0});
        exp_wr_q.push_back({ADDR_W'(1), w1});
        exp_wr_q.push_back({ADDR_W'(2), w2});
        exp_wr_q.push_back({ADDR_W'(3), w3});
        exp_run_q.push_back(run_c);
        if (has_read) begin
            exp_rd_q.push_back(ADDR_W'(RES_ADDR));
            exp_res_q.push_back(res);
            exp_lat_q.push_back(lat);
        end
    endtask

    task automatic wait_idle(input int max_cyc, output int when);
        when = -1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin
                when = cyc - start_c;
                break;
            end
        end
        if (when < 0) fail("idle_wait_bound");
    endtask

    task automatic goto_cycle(input int n);
        while (cyc - start_c < n) @(posedge clk);
        #1;
    endtask

    task automatic chk_drained(input string name);
        chk(name, {exp_wr_q.size(), exp_rd_q.size(), exp_res_q.size(), exp_run_q.size()}, '0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int t;
        #2 rst = 1'b0;
        #1;
        chk("reset_outputs", {bus.valid, bus.addr, bus.wstrb, bus.wdata, bus.run},   '0);
        chk("reset_status",  {busy, res_valid, err_timeout, res_data, dbg_state}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // zero-wait batch
        rd_word = 32'hDEAD_BEEF;
        done_mode = 0;
        expect_batch(32'h1, 32'h2, 32'h3, 32'h4, 5, 1'b1, 32'hDEAD_BEEF, 9);
        start_batch(32'h1, 32'h2, 32'h3, 32'h4);
        wait_idle(50, t);
        chk("zw_idle_cycle", t, 10);
        chk_drained("zw_drained");

        // backpressure on second write and on the read
        wr_stall[1] = 3;
        rd_stall    = 2;
        rd_word     = 32'h1234_5678;
        expect_batch(32'hA0, 32'hA1, 32'hA2, 32'hA3, 8, 1'b1, 32'h1234_5678, 14);
        start_batch(32'hA0, 32'hA1, 32'hA2, 32'hA3);
        wait_idle(50, t);
        chk("bp_idle_cycle", t, 15);
        chk_drained("bp_drained");
        wr_stall[1] = 0;
        rd_stall    = 0;

        // stale done
        done_mode = 1;
        rd_word   = 32'hCAFE_F00D;
        expect_batch(32'h11, 32'h22, 32'h33, 32'h44, 5, 1'b1, 32'hCAFE_F00D, 14);
        start_batch(32'h11, 32'h22, 32'h33, 32'h44);
        wait_idle(50, t);
        chk("stale_idle_cycle", t, 15);
        chk_drained("stale_drained");

        // start pulses during WAIT and during the res_valid cycle are ignored
        rd_word = 32'h0BAD_F00D;
        expect_batch(32'h10, 32'h20, 32'h30, 32'h40, 5, 1'b1, 32'h0BAD_F00D, 14);
        start_batch(32'h10, 32'h20, 32'h30, 32'h40);
        goto_cycle(8);
        w_in  = {32'h9993, 32'h9992, 32'h9991, 32'h9990};
        start = 1'b1;
        goto_cycle(9);
        start = 1'b0;
        goto_cycle(14);
        start = 1'b1;
        goto_cycle(15);
        start = 1'b0;
        @(negedge clk);
        chk("busy_ign_c15", busy, 1'b0);
        @(negedge clk);
        chk("busy_ign_c16", busy, 1'b0);
        chk_drained("ignore_drained");

        // timeout after 10 counted WAIT cycles
        done_mode   = 2;
        timeout_lim = 16'd10;
        expect_batch(32'h5, 32'h6, 32'h7, 32'h8, 5, 1'b0, '0, 0);
        start_batch(32'h5, 32'h6, 32'h7, 32'h8);
        wait_idle(50, t);
        chk("to_idle_cycle", t, 17);
        chk("to_err_set", err_timeout, 1'b1);
        chk("to_res_held", res_data, 32'h0BAD_F00D);
        chk_drained("to_drained");

        // timeout disabled: next start clears the flag, WAIT holds indefinitely
        timeout_lim = '0;
        expect_batch(32'hC0, 32'hC1, 32'hC2, 32'hC3, 5, 1'b0, '0, 0);
        start_batch(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        @(negedge clk);
        chk("err_cleared", err_timeout, 1'b0);
        repeat (1000) @(negedge clk);
        chk("nolim_wait_state", {busy, dbg_state}, {1'b1, 3'd3});
        chk("nolim_no_err", err_timeout, 1'b0);
        rd_word = 32'h7777_0001;
        exp_rd_q.push_back(ADDR_W'(RES_ADDR));
        exp_res_q.push_back(32'h7777_0001);
        exp_lat_q.push_back(-1);
        done_mode = 0;
        wait_idle(20, t);
        chk_drained("nolim_drained");

        // asynchronous reset in the middle of a stalled write
        wr_stall[0] = 6;
        start_batch(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_valid", bus.valid, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_bus", {bus.valid, bus.addr, bus.wstrb, bus.wdata, bus.run}, '0);
        chk("midrst_status", {busy, res_valid, err_timeout, res_data, dbg_state}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr_stall[0] = 0;
        @(negedge clk);
        chk("post_reset_idle", {busy, dbg_state}, '0);

        // recovery batch after reset
        rd_word = 32'h5555_AAAA;
        expect_batch(32'hF0, 32'hF1, 32'hF2, 32'hF3, 5, 1'b1, 32'h5555_AAAA, 9);
        start_batch(32'hF0, 32'hF1, 32'hF2, 32'hF3);
        wait_idle(50, t);
        chk("rec_idle_cycle", t, 10);
        chk_drained("rec_drained");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_bound: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "time bound expired");
    end

endmodule
